// File: rtl/craps_if.sv
// Handshake bundle between the craps game controller and the dice datapath.
// The controller drives roll and the set-point enable. The datapath returns
// the captured dice, their sum, the point register and the outcome flags.
interface craps_if;
    logic       roll;
    logic       sp;
    logic [2:0] die1;
    logic [2:0] die2;
    logic [3:0] sum;
    logic [3:0] point;
    logic       point_valid;
    logic       result_valid;
    logic       natural;
    logic       craps;
    logic       eq;
    logic       seven_out;

    modport master (
        output roll, sp,
        input  die1, die2, sum, point, point_valid, result_valid,
        input  natural, craps, eq, seven_out
    );

    modport slave (
        input  roll, sp,
        output die1, die2, sum, point, point_valid, result_valid,
        output natural, craps, eq, seven_out
    );
endinterface

// File: rtl/craps_datapath.sv
// Dice datapath for the craps controller.
// Two chained spinners run while roll is high. When roll drops, the dice are
// captured one cycle later, together with their sum and the outcome flags.
// Which flags apply depends on whether this is a first roll (sp high) or a
// point roll against a previously stored point.
module craps_datapath #(
    parameter logic [2:0] SEED1 = 3'd1,
    parameter logic [2:0] SEED2 = 3'd1
) (
    input  logic clk_main,
    input  logic reset,
    craps_if.slave bus
);

    logic [2:0] s1;
    logic [2:0] s2;
    logic       roll_q;

    logic [2:0] die1_r;
    logic [2:0] die2_r;
    logic [3:0] sum_r;
    logic [3:0] point_r;
    logic       point_valid_r;
    logic       result_valid_r;
    logic       natural_r;
    logic       craps_r;
    logic       eq_r;
    logic       seven_out_r;

    logic       capture;
    logic [3:0] next_sum;
    logic       is_natural;
    logic       is_craps;

    // Capture happens on the first edge that sees roll low after it was high.
    // The sum and its first-roll classification are taken from the live spinners.
    always_comb begin
        capture    = 1'b0;
        next_sum   = 4'd0;
        is_natural = 1'b0;
        is_craps   = 1'b0;

        capture    = !bus.roll && roll_q;
        next_sum   = {1'b0, s1} + {1'b0, s2};
        is_natural = (next_sum == 4'd7) || (next_sum == 4'd11);
        is_craps   = (next_sum == 4'd2) || (next_sum == 4'd3) || (next_sum == 4'd12);
    end

    // Delayed copy of roll, used to detect its falling edge.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            roll_q <= 1'b0;
        end else begin
            roll_q <= bus.roll;
        end
    end

    // Die 1 counts 1..6 while rolling. Die 2 steps only when die 1 wraps,
    // so the pair walks through all 36 combinations in a fixed order.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            s1 <= SEED1;
            s2 <= SEED2;
        end else if (bus.roll) begin
            if (s1 == 3'd6) begin
                s1 <= 3'd1;
                s2 <= (s2 == 3'd6) ? 3'd1 : s2 + 3'd1;
            end else begin
                s1 <= s1 + 3'd1;
            end
        end
    end

    // Registers the dice, sum, flags and point on a capture edge; they hold otherwise.
    always_ff @(posedge clk_main or posedge reset) begin
        if (reset) begin
            die1_r         <= 3'd0;
            die2_r         <= 3'd0;
            sum_r          <= 4'd0;
            point_r        <= 4'd0;
            point_valid_r  <= 1'b0;
            result_valid_r <= 1'b0;
            natural_r      <= 1'b0;
            craps_r        <= 1'b0;
            eq_r           <= 1'b0;
            seven_out_r    <= 1'b0;
        end else begin
            result_valid_r <= capture;
            if (capture) begin
                die1_r <= s1;
                die2_r <= s2;
                sum_r  <= next_sum;
                if (bus.sp) begin
                    natural_r   <= is_natural;
                    craps_r     <= is_craps;
                    eq_r        <= 1'b0;
                    seven_out_r <= 1'b0;
                    if (!is_natural && !is_craps) begin
                        point_r       <= next_sum;
                        point_valid_r <= 1'b1;
                    end
                end else if (point_valid_r) begin
                    natural_r   <= 1'b0;
                    craps_r     <= 1'b0;
                    eq_r        <= (next_sum == point_r);
                    seven_out_r <= (next_sum == 4'd7);
                end else begin
                    natural_r   <= 1'b0;
                    craps_r     <= 1'b0;
                    eq_r        <= 1'b0;
                    seven_out_r <= 1'b0;
                end
            end
        end
    end

    assign bus.die1         = die1_r;
    assign bus.die2         = die2_r;
    assign bus.sum          = sum_r;
    assign bus.point        = point_r;
    assign bus.point_valid  = point_valid_r;
    assign bus.result_valid = result_valid_r;
    assign bus.natural      = natural_r;
    assign bus.craps        = craps_r;
    assign bus.eq           = eq_r;
    assign bus.seven_out    = seven_out_r;

endmodule

// File: tb/tb_craps_datapath.sv
// Testbench for craps_datapath.
// A reference model tracks the spinner as a single index 0..35 (die1 is the
// low base-6 digit, die2 the high one). Every roll pushes its expected
// capture onto a scoreboard queue, and the entry is popped when result_valid appears.
module tb_craps_datapath;

    logic clk_main;
    logic reset;

    craps_if bus ();

    craps_datapath #(
        .SEED1(3'd1),
        .SEED2(3'd1)
    ) dut (
        .clk_main(clk_main),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int die1;
        int die2;
        int sum;
        int point;
        int point_valid;
        int natural;
        int craps;
        int eq;
        int seven_out;
    } exp_t;

    exp_t scoreboard[$];

    int checks   = 0;
    int failures = 0;

    int spin_idx;
    int m_point;
    int m_point_valid;
    int m_die1;
    int m_sum;

    initial clk_main = 1'b0;
    always #5 clk_main = ~clk_main;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " die1"}, 32'(bus.die1), 0);
        check_output({tag, " die2"}, 32'(bus.die2), 0);
        check_output({tag, " sum"}, 32'(bus.sum), 0);
        check_output({tag, " point"}, 32'(bus.point), 0);
        check_output({tag, " point_valid"}, 32'(bus.point_valid), 0);
        check_output({tag, " result_valid"}, 32'(bus.result_valid), 0);
        check_output({tag, " flags"}, 32'({bus.natural, bus.craps, bus.eq, bus.seven_out}), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_main);
        reset    = 1'b1;
        bus.roll = 1'b0;
        bus.sp   = 1'b0;
        spin_idx      = 0;
        m_point       = 0;
        m_point_valid = 0;
        m_die1        = 0;
        m_sum         = 0;
        scoreboard.delete();
        repeat (2) @(negedge clk_main);
        reset = 1'b0;
    endtask

    // Predicts the outcome of a capture from the model state and pushes it.
    task automatic push_expected(input bit sp_cap);
        exp_t e;
        e.die1      = spin_idx % 6 + 1;
        e.die2      = spin_idx / 6 + 1;
        e.sum       = e.die1 + e.die2;
        e.natural   = 0;
        e.craps     = 0;
        e.eq        = 0;
        e.seven_out = 0;
        if (sp_cap) begin
            e.natural = (e.sum == 7 || e.sum == 11) ? 1 : 0;
            e.craps   = (e.sum == 2 || e.sum == 3 || e.sum == 12) ? 1 : 0;
            if (e.natural == 0 && e.craps == 0) begin
                m_point       = e.sum;
                m_point_valid = 1;
            end
        end else if (m_point_valid != 0) begin
            e.eq        = (e.sum == m_point) ? 1 : 0;
            e.seven_out = (e.sum == 7) ? 1 : 0;
        end
        e.point       = m_point;
        e.point_valid = m_point_valid;
        m_die1 = e.die1;
        m_sum  = e.sum;
        scoreboard.push_back(e);
    endtask

    // Holds roll high for the given number of edges, then drops it and checks
    // the capture that must follow on the very next edge.
    task automatic apply_stimulus(input int cycles, input bit sp_spin, input bit sp_cap, input bit check_hold);
        exp_t e;
        int waited;
        @(negedge clk_main);
        bus.sp   = sp_spin;
        bus.roll = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_main);
            spin_idx = (spin_idx + 1) % 36;
            if (check_hold) begin
                check_output("hold result_valid", 32'(bus.result_valid), 0);
                check_output("hold die1", 32'(bus.die1), 32'(m_die1));
                check_output("hold sum", 32'(bus.sum), 32'(m_sum));
            end
        end
        bus.sp   = sp_cap;
        bus.roll = 1'b0;
        push_expected(sp_cap);

        waited = 0;
        do begin
            @(negedge clk_main);
            waited++;
        end while (bus.result_valid !== 1'b1 && waited < 8);
        check_output("capture latency", 32'(waited), 1);

        e = scoreboard.pop_front();
        if (bus.result_valid === 1'b1) begin
            check_output("die1", 32'(bus.die1), 32'(e.die1));
            check_output("die2", 32'(bus.die2), 32'(e.die2));
            check_output("sum", 32'(bus.sum), 32'(e.sum));
            check_output("natural", 32'(bus.natural), 32'(e.natural));
            check_output("craps", 32'(bus.craps), 32'(e.craps));
            check_output("eq", 32'(bus.eq), 32'(e.eq));
            check_output("seven_out", 32'(bus.seven_out), 32'(e.seven_out));
            check_output("point", 32'(bus.point), 32'(e.point));
            check_output("point_valid", 32'(bus.point_valid), 32'(e.point_valid));
            @(negedge clk_main);
            check_output("result_valid pulse width", 32'(bus.result_valid), 0);
            check_output("die1 after pulse", 32'(bus.die1), 32'(e.die1));
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.roll = 1'b0;
        bus.sp   = 1'b0;

        $display("[TB] reset state");
        do_reset();
        check_all_zero("reset");

        $display("[TB] first roll natural 7");
        apply_stimulus(5, 1'b1, 1'b1, 1'b0);

        $display("[TB] first roll craps 3 after spinner wrap");
        do_reset();
        apply_stimulus(6, 1'b1, 1'b1, 1'b0);

        $display("[TB] point 6 then matching point roll");
        do_reset();
        apply_stimulus(4, 1'b1, 1'b1, 1'b0);
        apply_stimulus(5, 1'b0, 1'b0, 1'b0);

        $display("[TB] point roll miss, seven out, point overwrite");
        do_reset();
        apply_stimulus(4, 1'b1, 1'b1, 1'b0);
        apply_stimulus(7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(4, 1'b0, 1'b0, 1'b0);
        apply_stimulus(3, 1'b0, 1'b1, 1'b0);
        apply_stimulus(2, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a roll");
        @(negedge clk_main);
        bus.roll = 1'b1;
        bus.sp   = 1'b1;
        repeat (3) @(negedge clk_main);
        reset    = 1'b1;
        bus.roll = 1'b0;
        spin_idx      = 0;
        m_point       = 0;
        m_point_valid = 0;
        m_die1        = 0;
        m_sum         = 0;
        @(negedge clk_main);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_main);
            check_all_zero("after mid-roll reset");
        end
        apply_stimulus(1, 1'b0, 1'b0, 1'b0);

        $display("[TB] roll held high for 40 cycles");
        do_reset();
        apply_stimulus(40, 1'b1, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
